// File: rtl/mac_fc_vec.sv
// mac_fc_vec: multi-lane streaming dot-product engine for fully-connected layers.
//
// A job computes, for each of LANES output neurons, bias[k] + sum(a * w[k]) over
// a programmable number of beats. Every beat carries one shared activation and
// one weight per lane. After the last beat the sums pass through optional ReLU and
// saturation to OUT_BITWIDTH, and are held on mout until the consumer takes them.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start, len, relu_en, bias
//                        job request and per-job settings, sampled only in IDLE
//   in_valid, in_ready   beat handshake; a beat is taken when both are high
//   data_a               shared signed activation
//   data_b               per-lane signed weights, lane k at [k*B_BITWIDTH +: B_BITWIDTH]
//   out_valid, out_ready result handshake; results stay stable while stalled
//   mout                 per-lane saturated results, lane k at [k*OUT_BITWIDTH +: OUT_BITWIDTH]
//   sat                  per-lane saturation flags, valid with out_valid
//   busy                 high whenever a job is in flight
//
// Pipeline: beat accepted (cycle T) -> product register -> accumulator ->
// result register, so out_valid rises in cycle T+3.
module mac_fc_vec #(
  parameter int A_BITWIDTH   = 8,
  parameter int B_BITWIDTH   = 8,
  parameter int LANES        = 4,
  parameter int ACC_BITWIDTH = 24,
  parameter int C_BITWIDTH   = 16,
  parameter int OUT_BITWIDTH = 16,
  parameter int LEN_BITWIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [LEN_BITWIDTH-1:0]         len,
  input  logic                            relu_en,
  input  logic [LANES*C_BITWIDTH-1:0]     bias,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [A_BITWIDTH-1:0]           data_a,
  input  logic [LANES*B_BITWIDTH-1:0]     data_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*OUT_BITWIDTH-1:0]   mout,
  output logic [LANES-1:0]                sat,
  output logic                            busy
);

  localparam int P_W = A_BITWIDTH + B_BITWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [ACC_BITWIDTH-1:0] OUT_MAX_ACC = ACC_BITWIDTH'((2 ** (OUT_BITWIDTH - 1)) - 1);
  localparam logic signed [ACC_BITWIDTH-1:0] OUT_MIN_ACC = ACC_BITWIDTH'(-(2 ** (OUT_BITWIDTH - 1)));
  localparam logic [OUT_BITWIDTH-1:0] OUT_MAX = {1'b0, {(OUT_BITWIDTH - 1){1'b1}}};
  localparam logic [OUT_BITWIDTH-1:0] OUT_MIN = {1'b1, {(OUT_BITWIDTH - 1){1'b0}}};

  // Returns {sat_flag, clipped_value}. ReLU is applied before the range check,
  // so a negative sum with ReLU on yields 0 without a saturation flag.
  function automatic logic [OUT_BITWIDTH:0] saturate(
    input logic signed [ACC_BITWIDTH-1:0] v,
    input logic                           relu
  );
    logic signed [ACC_BITWIDTH-1:0] x;
    x = (relu && v[ACC_BITWIDTH-1]) ? '0 : v;
    if (x > OUT_MAX_ACC)
      saturate = {1'b1, OUT_MAX};
    else if (x < OUT_MIN_ACC)
      saturate = {1'b1, OUT_MIN};
    else
      saturate = {1'b0, x[OUT_BITWIDTH-1:0]};
  endfunction

  logic [1:0]                     state;
  logic [LEN_BITWIDTH-1:0]        cnt;
  logic                           relu_q;
  logic                           beat_ok;
  logic                           start_ok;
  logic                           vld_p1;
  logic signed [P_W-1:0]          prod_p1 [LANES];
  logic signed [ACC_BITWIDTH-1:0] acc_p2  [LANES];
  logic [LANES*OUT_BITWIDTH-1:0]  mout_p3;
  logic [LANES-1:0]               sat_p3;

  assign beat_ok  = in_valid && (state == S_ACCUM);
  assign start_ok = start && (state == S_IDLE);

  // Job control: beat counter and state sequencing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= len;
            relu_q <= relu_en;
            state  <= (len == '0) ? S_DRAIN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat_ok) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_BITWIDTH'(1))
              state <= S_DRAIN;
          end
        end
        // Wait until the final product has been folded into the accumulators.
        S_DRAIN: begin
          if (!vld_p1)
            state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: per-lane product of the shared activation and the lane weight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < LANES; k++)
        prod_p1[k] <= '0;
    end else begin
      vld_p1 <= beat_ok;
      if (beat_ok) begin
        for (int k = 0; k < LANES; k++)
          prod_p1[k] <= P_W'($signed(data_a)) * P_W'($signed(data_b[k*B_BITWIDTH +: B_BITWIDTH]));
      end
    end
  end

  // Stage 2: accumulators, seeded with the bias at job start so nothing carries
  // over from the previous job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LANES; k++)
        acc_p2[k] <= '0;
    end else if (start_ok) begin
      for (int k = 0; k < LANES; k++)
        acc_p2[k] <= ACC_BITWIDTH'($signed(bias[k*C_BITWIDTH +: C_BITWIDTH]));
    end else if (vld_p1) begin
      for (int k = 0; k < LANES; k++)
        acc_p2[k] <= acc_p2[k] + ACC_BITWIDTH'(prod_p1[k]);
    end
  end

  // Stage 3: result register, loaded once per job as DRAIN hands over to OUT and
  // then held untouched through any back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mout_p3 <= '0;
      sat_p3  <= '0;
    end else if ((state == S_DRAIN) && !vld_p1) begin
      for (int k = 0; k < LANES; k++)
        {sat_p3[k], mout_p3[k*OUT_BITWIDTH +: OUT_BITWIDTH]} <= saturate(acc_p2[k], relu_q);
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign mout      = mout_p3;
  assign sat       = sat_p3;

endmodule

// File: tb/tb_mac_fc_vec.sv
// Directed bench for mac_fc_vec: a table of jobs with hand-computed per-lane
// results, run back to back, followed by hand-written sequences for
// back-pressure, ignored starts and asynchronous reset.
// The accumulator is sized by the rule A+B+LEN bits so that the 600-beat
// saturation jobs do not wrap.
module tb_mac_fc_vec;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len = '0;
  logic        relu_en = 1'b0;
  logic [63:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  data_a = '0;
  logic [31:0] data_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] mout;
  logic [3:0]  sat;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mac_fc_vec #(.ACC_BITWIDTH(26)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .relu_en(relu_en),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .data_a(data_a),
    .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .mout(mout), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              len;
    bit              relu;
    int              a_base;
    int              a_step;
    logic [3:0][31:0] bias;
    logic [3:0][31:0] w;
    logic [3:0][31:0] exp;
    logic [3:0]      exp_sat;
  } vec_t;

  function automatic vec_t mk(input int l, input bit r, input int ab, input int as,
                              input int b0, input int b1, input int b2, input int b3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int e0, input int e1, input int e2, input int e3,
                              input logic [3:0] es);
    vec_t v;
    v.len = l; v.relu = r; v.a_base = ab; v.a_step = as;
    v.bias[0] = b0; v.bias[1] = b1; v.bias[2] = b2; v.bias[3] = b3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp_sat = es;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_out(input int k);
    logic signed [15:0] s;
    s = mout[k*16 +: 16];
    return int'(s);
  endfunction

  // Issues a job and feeds its beats; returns with results pending (out_ready low).
  task automatic run_job(input vec_t v, input bit gaps, input string tag);
    int i;
    int guard;
    int lat;
    bit took;
    len = 10'(v.len);
    relu_en = v.relu;
    for (int k = 0; k < LANES; k++)
      bias[k*16 +: 16] = v.bias[k][15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy"}, int'(busy), 1);
    i = 0;
    guard = 0;
    while (i < v.len && guard < 5000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_a = 8'(v.a_base + i * v.a_step);
      for (int k = 0; k < LANES; k++)
        data_b[k*8 +: 8] = v.w[k][7:0];
      took = in_valid && in_ready;
      tick();
      if (took) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk({tag, " beats"}, i, v.len);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    // Ticks after the last accepting edge (or the start edge for an empty job).
    chk({tag, " latency"}, lat, (v.len == 0) ? 1 : 2);
    for (int k = 0; k < LANES; k++)
      chk($sformatf("%s mout[%0d]", tag, k), lane_out(k), int'(v.exp[k]));
    chk({tag, " sat"}, int'(sat), int'(v.exp_sat));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, int'(out_valid), 0);
    chk({tag, " busy after accept"}, int'(busy), 0);
  endtask

  vec_t vecs[10];
  vec_t v5;

  initial begin
    vecs[0] = mk(3, 0, 1, 1,  0, 10, -10, 5,  1, 1, 1, 1,  6, 16, -4, 11, 4'b0000);
    vecs[1] = mk(4, 0, 2, 1,  0, 0, 100, 0,  1, -1, 2, -3,  14, -14, 128, -42, 4'b0000);
    vecs[2] = mk(4, 1, 2, 1,  0, 0, 100, 0,  1, -1, 2, -3,  14, 0, 128, 0, 4'b0000);
    vecs[3] = mk(0, 1, 0, 0,  -7, 3, 0, -1,  0, 0, 0, 0,  0, 3, 0, 0, 4'b0000);
    vecs[4] = mk(0, 0, 0, 0,  -7, 3, 0, -1,  0, 0, 0, 0,  -7, 3, 0, -1, 4'b0000);
    vecs[5] = mk(600, 0, 127, 0,  0, 0, 0, 0,  127, 127, 127, 127,
                 32767, 32767, 32767, 32767, 4'b1111);
    vecs[6] = mk(600, 0, -128, 0,  0, 0, 0, 0,  127, 127, 127, 127,
                 -32768, -32768, -32768, -32768, 4'b1111);
    vecs[7] = mk(1, 0, 1, 0,  32767, -32768, 32767, -32768,  1, -1, 0, 0,
                 32767, -32768, 32767, -32768, 4'b0011);
    vecs[8] = mk(1, 1, 1, 0,  32767, -32768, 32767, -32768,  1, -1, 0, 0,
                 32767, 0, 32767, 0, 4'b0001);
    vecs[9] = mk(5, 0, -3, 2,  0, 0, 0, 0,  10, -10, 127, -128,  50, -50, 635, -640, 4'b0000);
    v5 = mk(8, 0, 1, 1,  0, 0, 0, 0,  1, 2, -1, -3,  36, 72, -36, -108, 4'b0000);

    // Reset state.
    tick();
    tick();
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset mout", int'(mout != '0), 0);
    chk("reset sat", int'(sat), 0);
    rstn = 1'b1;
    tick();

    // Table jobs, each started on the cycle right after the previous accept.
    for (int n = 0; n < 10; n++) begin
      run_job(vecs[n], 1'b0, $sformatf("vec%0d", n));
      accept($sformatf("vec%0d", n));
    end

    // Random beat gaps, stalled output, starts ignored while results are pending.
    run_job(v5, 1'b1, "gaps");
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      len = 10'd2;
      bias = {4{16'h1234}};
      tick();
      chk($sformatf("stall%0d out_valid", c), int'(out_valid), 1);
      chk($sformatf("stall%0d mout[0]", c), lane_out(0), 36);
      chk($sformatf("stall%0d mout[3]", c), lane_out(3), -108);
      chk($sformatf("stall%0d sat", c), int'(sat), 0);
    end
    // Start coinciding with the accept edge is also ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("accept+start busy", int'(busy), 0);
    chk("accept+start out_valid", int'(out_valid), 0);

    // Back-to-back after a job with large accumulators: no carry-over.
    run_job(vecs[5], 1'b0, "b2b_a");
    accept("b2b_a");
    run_job(mk(2, 0, 1, 0,  0, 0, 0, 0,  1, 1, 1, 1,  2, 2, 2, 2, 4'b0000), 1'b0, "b2b_b");

    // Reset while results are held.
    #1 rstn = 1'b0;
    #1;
    chk("rst_out out_valid", int'(out_valid), 0);
    chk("rst_out busy", int'(busy), 0);
    chk("rst_out mout", int'(mout != '0), 0);
    chk("rst_out sat", int'(sat), 0);
    #1 rstn = 1'b1;
    tick();

    // Reset in the middle of accumulation.
    len = 10'd5;
    relu_en = 1'b0;
    bias = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    data_a = 8'd3;
    data_b = {4{8'd2}};
    tick();
    tick();
    chk("mid in_ready before reset", int'(in_ready), 1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid in_ready", int'(in_ready), 0);
    chk("rst_mid out_valid", int'(out_valid), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid mout", int'(mout != '0), 0);
    in_valid = 1'b0;
    #1 rstn = 1'b1;
    tick();

    // First job after reset starts from a clean pipe.
    run_job(vecs[0], 1'b0, "post_rst");
    accept("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
